seq_add_sub: RTL and testbench

Multi-cycle, parametrised two's-complement adder/subtractor with a start/done handshake. It processes a WIDTH-bit operand pair DIGIT bits per clock, using a single DIGIT-bit adder slice and a registered carry. This trades latency for area compared with a full-width ripple adder. It sits in the datapath wherever wide add/subtract results are not needed in one cycle, and reports unsigned carry/borrow and signed overflow.

---
 rtl/seq_add_sub.sv | 146 ++++++++++++++
 tb/tb_seq_add_sub.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seq_add_sub.sv
// seq_add_sub: multi-cycle two's-complement adder/subtractor.
// Processes a WIDTH-bit operand pair DIGIT bits per clock through one
// DIGIT-bit adder slice and a registered carry; N = WIDTH/DIGIT digit cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request an operation (sampled only when not busy)
//   A, B       operands, captured on the accepted start edge
//   M          mode: 0 = A+B, 1 = A-B, captured with the operands
//   busy       high while an operation is in progress
//   done       one-cycle pulse when results update
//   sum        registered result
//   carry_out  carry from the MSB (subtract: 1 = no borrow)
//   overflow   signed overflow
module seq_add_sub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW    = DIGIT + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   a_sh, b_sh, res_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;

  logic               busy_d, done_d, load, step;
  logic [SW-1:0]      slice;
  logic [DIGIT-1:0]   digit_sum;
  logic               slice_carry, msb_cin, last;
  logic [WIDTH-1:0]   res_shifted;

  // Single DIGIT-bit adder slice with carry, plus result shift-in.
  always_comb begin
    slice       = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + SW'(carry);
    digit_sum   = slice[DIGIT-1:0];
    slice_carry = slice[DIGIT];
    // Carry into the top bit of the slice, recovered from its sum and inputs.
    msb_cin     = digit_sum[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
    // Digits enter at the top so the first (least significant) ends at bit 0.
    res_shifted = (res_sh >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));
    last        = (cnt == CNT_W'(N - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state and control decode.
  always_comb begin
    state_d = state;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        step   = 1'b1;
        busy_d = 1'b1;
        if (last) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      if (load) begin
        a_sh   <= A;
        b_sh   <= B ^ {WIDTH{M}};
        res_sh <= '0;
        cnt    <= '0;
        carry  <= M;
      end else if (step) begin
        a_sh   <= a_sh >> DIGIT;
        b_sh   <= b_sh >> DIGIT;
        res_sh <= res_shifted;
        carry  <= slice_carry;
        cnt    <= cnt + CNT_W'(1);
        if (last) begin
          sum       <= res_shifted;
          carry_out <= slice_carry;
          overflow  <= msb_cin ^ slice_carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_add_sub.sv
// Testbench for seq_add_sub: two instances (8-bit/1-bit digit and
// 16-bit/4-bit digit) driven by directed vectors with hand-computed results.
module tb_seq_add_sub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8-bit, 1 bit per clock
  logic        start8, m8, busy8, done8, co8, ov8;
  logic [7:0]  a8, b8, sum8;
  // 16-bit, 4 bits per clock
  logic        start16, m16, busy16, done16, co16, ov16;
  logic [15:0] a16, b16, sum16;

  int checks = 0;
  int errors = 0;

  seq_add_sub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .M(m8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8), .overflow(ov8)
  );

  seq_add_sub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16), .M(m16),
    .busy(busy16), .done(done16), .sum(sum16), .carry_out(co16), .overflow(ov16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_busy(input bit wide);
    return wide ? busy16 : busy8;
  endfunction

  function automatic logic get_done(input bit wide);
    return wide ? done16 : done8;
  endfunction

  task automatic drive(input bit wide, input logic s, input logic [15:0] a,
                       input logic [15:0] b, input logic m);
    if (wide) begin
      start16 = s; a16 = a; b16 = b; m16 = m;
    end else begin
      start8 = s; a8 = a[7:0]; b8 = b[7:0]; m8 = m;
    end
  endtask

  // One operation: start at the next negedge, check busy for N cycles
  // (operands scrambled after acceptance), then check done and results.
  // Returns right after the done cycle is sampled so a following call
  // drives start during DONE (back-to-back).
  task automatic run_op(input string tag, input bit wide, input logic [15:0] a,
                        input logic [15:0] b, input logic m,
                        input logic [15:0] exp_sum, input logic exp_c,
                        input logic exp_v, input bit stray);
    int n;
    n = wide ? 4 : 8;
    @(negedge clk);
    drive(wide, 1'b1, a, b, m);
    @(posedge clk); #1;
    check({tag, "_busy_rise"}, 32'(get_busy(wide)), 32'd1);
    check({tag, "_done_low0"}, 32'(get_done(wide)), 32'd0);
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      drive(wide, stray && (k == 2), 16'($urandom), 16'($urandom), 1'($urandom));
      @(posedge clk); #1;
      check({tag, "_busy_run"}, 32'(get_busy(wide)), 32'd1);
      check({tag, "_done_run"}, 32'(get_done(wide)), 32'd0);
    end
    @(negedge clk);
    drive(wide, 1'b0, 16'h0, 16'h0, 1'b0);
    @(posedge clk); #1;
    check({tag, "_busy_fall"}, 32'(get_busy(wide)), 32'd0);
    check({tag, "_done"}, 32'(get_done(wide)), 32'd1);
    if (wide) begin
      check({tag, "_sum"}, 32'(sum16), 32'(exp_sum));
      check({tag, "_carry"}, 32'(co16), 32'(exp_c));
      check({tag, "_ovf"}, 32'(ov16), 32'(exp_v));
    end else begin
      check({tag, "_sum"}, 32'(sum8), 32'(exp_sum[7:0]));
      check({tag, "_carry"}, 32'(co8), 32'(exp_c));
      check({tag, "_ovf"}, 32'(ov8), 32'(exp_v));
    end
  endtask

  // Idle cycles with start low: no busy, no done.
  task automatic idle(input string tag, input bit wide, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      check({tag, "_idle_busy"}, 32'(get_busy(wide)), 32'd0);
      check({tag, "_idle_done"}, 32'(get_done(wide)), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_sum8", 32'(sum8), 32'd0);
    check("rst_co8", 32'(co8), 32'd0);
    check("rst_ov8", 32'(ov8), 32'd0);
    check("rst_sum16", 32'(sum16), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 8-bit, DIGIT=1
    run_op("add_127", 1'b0, 16'd100, 16'd27, 1'b0, 16'd127, 1'b0, 1'b0, 1'b0);
    idle("add_127", 1'b0, 3);
    check("hold_sum8", 32'(sum8), 32'd127);
    check("hold_co8", 32'(co8), 32'd0);
    run_op("add_ovf", 1'b0, 16'd100, 16'd28, 1'b0, 16'h80, 1'b0, 1'b1, 1'b0);
    idle("add_ovf", 1'b0, 1);
    check("hold_ovf8", 32'(ov8), 32'd1);
    run_op("sub_neg", 1'b0, 16'd5, 16'd7, 1'b1, 16'hFE, 1'b0, 1'b0, 1'b0);
    idle("sub_neg", 1'b0, 1);
    run_op("sub_ovf", 1'b0, 16'h80, 16'h01, 1'b1, 16'h7F, 1'b1, 1'b1, 1'b0);
    idle("sub_ovf", 1'b0, 2);

    // 16-bit, DIGIT=4: stray start in RUN, then back-to-back chain
    run_op("w_wrap", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    idle("w_wrap", 1'b1, 2);
    run_op("w_b2b1", 1'b1, 16'h1234, 16'h0235, 1'b1, 16'h0FFF, 1'b1, 1'b0, 1'b0);
    run_op("w_b2b2", 1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    idle("w_b2b2", 1'b1, 1);

    // Reset during RUN cycle 3 aborts the operation and clears outputs
    @(negedge clk);
    drive(1'b0, 1'b1, 16'd100, 16'd27, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_sum", 32'(sum8), 32'd0);
    check("abort_co", 32'(co8), 32'd0);
    check("abort_ov", 32'(ov8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle("abort", 1'b0, 8);
    check("abort_sum_after", 32'(sum8), 32'd0);
    run_op("post_rst", 1'b0, 16'h0F, 16'hF1, 1'b0, 16'h00, 1'b1, 1'b0, 1'b0);
    idle("post_rst", 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
